xdp_swap_mac_pipeline: RTL and testbench

//  Streaming XDP "swap MAC" packet kernel on the NIC datapath: AXI4-Stream in (port0) -> AXI4-Stream out (port1).
//  The first beat of every frame has its 6-byte destination MAC and 6-byte source MAC exchanged.
//  All other bytes, tkeep, tuser and tlast pass through unchanged (XDP_TX on every packet, no drops).

---
 rtl/xdp_swap_mac_pipeline_if.sv | 17 +
 rtl/xdp_swap_mac_pipeline.sv | 113 +++++++++++
 tb/tb_xdp_swap_mac_pipeline.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xdp_swap_mac_pipeline_if.sv
// AXI4-Stream bundle used on both sides of the swap-MAC kernel.
// A beat transfers on a rising clock edge where tvalid && tready; the master holds tvalid and payload stable until then.
interface xdp_swap_mac_pipeline_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int USER_W = 48
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tkeep, output tlast, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tuser, input tvalid, output tready);
endinterface

// File: rtl/xdp_swap_mac_pipeline.sv
// XDP swap-MAC kernel: exchanges destination/source MAC on the first beat of every frame, everything else passes.
// S1 (modify) -> [2-entry skid] -> S2 (output); ingress ready is a register so it never sees egress ready combinationally.
module xdp_swap_mac_pipeline #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int USER_W = 48
) (
  input  logic ap_clk_0,
  input  logic ap_rst_0,
  xdp_swap_mac_pipeline_if.slave  port0_0,
  xdp_swap_mac_pipeline_if.master port1_0
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [USER_W-1:0] user;
    logic              last;
  } beat_t;

  beat_t      s1_q;
  beat_t      s2_q;
  beat_t      skid_q [2];
  beat_t      in_beat;
  logic       s1_valid;
  logic       s2_valid;
  logic [1:0] skid_cnt;
  logic [1:0] skid_cnt_nxt;
  logic       skid_rd;
  logic       skid_wr;
  logic       first_q;
  logic       in_ready_q;

  logic in_fire;
  logic s2_take;
  logic skid_pop;
  logic s1_to_s2;
  logic s1_to_skid;

  always_comb begin
    in_beat.data = port0_0.tdata;
    in_beat.keep = port0_0.tkeep;
    in_beat.user = port0_0.tuser;
    in_beat.last = port0_0.tlast;
    // Only a first beat that carries both complete MAC addresses is rewritten.
    if (first_q && (port0_0.tkeep[11:0] == 12'hFFF)) begin
      in_beat.data = {port0_0.tdata[DATA_W-1:96], port0_0.tdata[47:0], port0_0.tdata[95:48]};
    end
  end

  // S2 refills from the skid first (older beats), then directly from S1 when the skid is empty.
  always_comb begin
    in_fire      = port0_0.tvalid && in_ready_q;
    s2_take      = !s2_valid || port1_0.tready;
    skid_pop     = s2_take && (skid_cnt != 2'd0);
    s1_to_s2     = s2_take && (skid_cnt == 2'd0) && s1_valid;
    s1_to_skid   = s1_valid && !s1_to_s2 && ((skid_cnt != 2'd2) || skid_pop);
    skid_cnt_nxt = skid_cnt + {1'b0, s1_to_skid} - {1'b0, skid_pop};
  end

  always_ff @(posedge ap_clk_0 or posedge ap_rst_0) begin
    if (ap_rst_0) begin
      s1_q       <= '0;
      s2_q       <= '0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      skid_cnt   <= 2'd0;
      skid_rd    <= 1'b0;
      skid_wr    <= 1'b0;
      first_q    <= 1'b1;
      in_ready_q <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_q     <= in_beat;
        s1_valid <= 1'b1;
        first_q  <= port0_0.tlast;
      end else if (s1_to_s2 || s1_to_skid) begin
        s1_valid <= 1'b0;
      end

      if (s1_to_skid) begin
        skid_q[skid_wr] <= s1_q;
        skid_wr         <= ~skid_wr;
      end

      if (skid_pop) begin
        skid_rd <= ~skid_rd;
      end

      if (s2_take) begin
        s2_valid <= skid_pop || s1_to_s2;
        if (skid_pop) begin
          s2_q <= skid_q[skid_rd];
        end else if (s1_to_s2) begin
          s2_q <= s1_q;
        end
      end

      skid_cnt   <= skid_cnt_nxt;
      in_ready_q <= (skid_cnt_nxt != 2'd2);
    end
  end

  assign port0_0.tready = in_ready_q;
  assign port1_0.tvalid = s2_valid;
  assign port1_0.tdata  = s2_q.data;
  assign port1_0.tkeep  = s2_q.keep;
  assign port1_0.tuser  = s2_q.user;
  assign port1_0.tlast  = s2_q.last;

endmodule

// File: tb/tb_xdp_swap_mac_pipeline.sv
// Bench for the swap-MAC kernel: directed frames, expected beats queued at ingress, popped by an egress monitor.
module tb_xdp_swap_mac_pipeline;

  localparam int BW = 512 + 64 + 48 + 1;

  logic clk;
  logic rst;
  logic out_ready;
  int   cyc;
  int   checks;
  int   errors;
  int   last_acc_cyc;
  int   lat_cyc;
  logic lat_arm;
  int   run_len;
  int   max_run;
  logic [BW-1:0] exp_q[$];

  xdp_swap_mac_pipeline_if #(.DATA_W(512), .KEEP_W(64), .USER_W(48)) in_if ();
  xdp_swap_mac_pipeline_if #(.DATA_W(512), .KEEP_W(64), .USER_W(48)) out_if ();

  xdp_swap_mac_pipeline #(.DATA_W(512), .KEEP_W(64), .USER_W(48)) dut (
    .ap_clk_0 (clk),
    .ap_rst_0 (rst),
    .port0_0  (in_if),
    .port1_0  (out_if)
  );

  assign out_if.tready = out_ready;

  // clock / reset block
  initial clk = 1'b0;
  always #2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // driver tasks: called at a falling edge, return at the falling edge after the handshake
  task automatic send_beat(input logic [95:0] lo, input logic [31:0] tag, input logic [63:0] keep,
                           input logic last, input logic [47:0] user, input logic [95:0] exp_lo);
    logic [511:0] d;
    int guard;
    d = {{13{tag}}, lo};
    in_if.tdata  = d;
    in_if.tkeep  = keep;
    in_if.tlast  = last;
    in_if.tuser  = user;
    in_if.tvalid = 1'b1;
    guard = 0;
    while (!in_if.tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_if.tready) begin
      checks++;
      errors++;
      $display("FAIL ingress_timeout: tready=%b after %0d cycles, required 1", in_if.tready, guard);
    end else begin
      last_acc_cyc = cyc;
      exp_q.push_back({d[511:96], exp_lo, keep, user, last});
    end
    @(negedge clk);
    in_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  // scoreboard monitor: samples just after the falling edge, i.e. the values the next rising edge will use
  logic [BW-1:0] held;
  logic          stalled_prev;
  logic          xfer_prev;
  int            beat_no;

  always @(negedge clk) begin
    logic [BW-1:0] cur;
    logic [BW-1:0] exp_v;
    logic          xfer;
    #1;
    cur  = {out_if.tdata, out_if.tkeep, out_if.tuser, out_if.tlast};
    xfer = out_if.tvalid && out_ready;
    if (rst) begin
      stalled_prev = 1'b0;
      xfer_prev    = 1'b0;
    end else begin
      if (lat_arm && out_if.tvalid) begin
        lat_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (stalled_prev) begin
        checks++;
        if (!out_if.tvalid || cur !== held) begin
          errors++;
          $display("FAIL stall_hold: tvalid=%b data[95:0]=%h, required tvalid=1 data[95:0]=%h",
                   out_if.tvalid, out_if.tdata[95:0], held[BW-1-416 -: 96]);
        end
      end
      if (xfer) begin
        checks++;
        beat_no++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat %0d: data[95:0]=%h, required no beat", beat_no, out_if.tdata[95:0]);
        end else begin
          exp_v = exp_q.pop_front();
          if (cur !== exp_v) begin
            errors++;
            $display("FAIL beat %0d: got data=%h keep=%h user=%h last=%b, required data=%h keep=%h user=%h last=%b",
                     beat_no, cur[BW-1 -: 512], cur[112:49], cur[48:1], cur[0],
                     exp_v[BW-1 -: 512], exp_v[112:49], exp_v[48:1], exp_v[0]);
          end
        end
        run_len = xfer_prev ? run_len + 1 : 1;
        if (run_len > max_run) max_run = run_len;
      end
      stalled_prev = out_if.tvalid && !out_ready;
      xfer_prev    = xfer;
    end
    held = cur;
  end

  initial begin
    int acc;
    logic dropped;
    logic seen;
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    lat_arm      = 1'b0;
    lat_cyc      = 0;
    run_len      = 0;
    max_run      = 0;
    beat_no      = 0;
    stalled_prev = 1'b0;
    xfer_prev    = 1'b0;
    rst          = 1'b1;
    out_ready    = 1'b1;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = '0;

    // reset held for 5 cycles
    repeat (5) @(negedge clk);
    check_bit("reset_out_tvalid", out_if.tvalid, 1'b0);
    check_bit("reset_in_tready", in_if.tready, 1'b0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (in_if.tready) seen = 1'b1;
    end
    check_bit("tready_after_reset", seen, 1'b1);

    // IPv4 frame then IPv6 frame back to back, with first-beat latency measured
    max_run = 0;
    lat_arm = 1'b1;
    send_beat(96'h0101_0000_0002_0301_0000_0002, 32'hC0DE_0001, {64{1'b1}}, 1'b0, 48'h62,
              96'h0301_0000_0002_0101_0000_0002);
    acc = last_acc_cyc;
    send_beat(96'h0800_4500_0054_1234_4000_4001, 32'hC0DE_0002, 64'hFFFF_FFFF, 1'b1, 48'h62,
              96'h0800_4500_0054_1234_4000_4001);
    send_beat(96'hda80_0586_0000_ea69_0797_6000, 32'hC0DE_0003, {64{1'b1}}, 1'b0, 48'h46,
              96'hea69_0797_6000_da80_0586_0000);
    send_beat(96'h0000_0000_0000_0000_0000_0001, 32'hC0DE_0004, 64'h3F, 1'b1, 48'h46,
              96'h0000_0000_0000_0000_0000_0001);
    wait_drain("ipv4_ipv6");
    checks++;
    if (lat_cyc - acc != 2) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required 2", lat_cyc - acc);
    end
    checks++;
    if (max_run < 4) begin
      errors++;
      $display("FAIL back_to_back: longest egress run %0d beats, required 4", max_run);
    end

    // back-pressure mid-frame for 10 cycles
    dropped = 1'b0;
    fork
      begin
        send_beat(96'h1111_2222_3333_4444_5555_6666, 32'hBEEF_0001, {64{1'b1}}, 1'b0, 48'h1A0,
                  96'h4444_5555_6666_1111_2222_3333);
        for (int b = 2; b <= 6; b++) begin
          send_beat(96'h0 + 96'(b * 17), 32'hBEEF_0000 + 32'(b), {64{1'b1}}, (b == 6), 48'h1A0,
                    96'h0 + 96'(b * 17));
        end
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (i < 3 && !in_if.tready) dropped = 1'b1;
        end
        out_ready = 1'b1;
      end
    join
    check_bit("stall_tready_drop", dropped, 1'b1);
    wait_drain("backpressure");

    // runt single-beat frame passes untouched, the next frame is swapped
    send_beat(96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF, 32'h5EED_0001, 64'h3FF, 1'b1, 48'h3C,
              96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF);
    send_beat(96'h0000_1111_2222_3333_4444_5555, 32'h5EED_0002, {64{1'b1}}, 1'b0, 48'h40,
              96'h3333_4444_5555_0000_1111_2222);
    send_beat(96'h1234_5678_9ABC_DEF0_1234_5678, 32'h5EED_0003, {64{1'b1}}, 1'b1, 48'h40,
              96'h1234_5678_9ABC_DEF0_1234_5678);
    wait_drain("runt");

    // reset in the middle of a frame whose first beat is stuck at the output
    out_ready = 1'b0;
    send_beat(96'h0102_0304_0506_0708_090A_0B0C, 32'hDEAD_0001, {64{1'b1}}, 1'b0, 48'h80,
              96'h0708_090A_0B0C_0102_0304_0506);
    repeat (3) @(negedge clk);
    check_bit("held_before_reset", out_if.tvalid, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("async_reset_tvalid", out_if.tvalid, 1'b0);
    check_bit("async_reset_tready", in_if.tready, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    send_beat(96'hA1A2_A3A4_A5A6_B1B2_B3B4_B5B6, 32'hF00D_0001, {64{1'b1}}, 1'b0, 48'h50,
              96'hB1B2_B3B4_B5B6_A1A2_A3A4_A5A6);
    send_beat(96'h0000_0000_0000_0000_FFFF_0000, 32'hF00D_0002, 64'hFF, 1'b1, 48'h50,
              96'h0000_0000_0000_0000_FFFF_0000);
    wait_drain("after_reset");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
